// File: rtl/vmult_pkg.sv
// Shared defaults, FSM state type and FP16 constants for the sequential vector multiplier.
package vmult_pkg;

    localparam int unsigned LANES_DEF = 8;
    localparam int unsigned FP_W_DEF  = 16;

    // Magnitude of the largest finite half-precision value (exponent 30, full mantissa).
    localparam logic [14:0] FP16_MAX_FINITE = 15'h7BFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vmult_seq.sv
// Sequential element-wise FP16 vector multiplier driving an external combinational multiplier.
// Define VMULT_SAT_EN to clamp overflowed lanes to signed max-finite instead of the raw product.
module vmult_seq
    import vmult_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned FP_W  = FP_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LANES*FP_W-1:0] vec_a,
    input  logic [LANES*FP_W-1:0] vec_b,
    output logic [FP_W-1:0]       mul_a,
    output logic [FP_W-1:0]       mul_b,
    input  logic [FP_W-1:0]       mul_prod,
    input  logic                  mul_ovf,
    output logic                  busy,
    output logic                  done,
    output logic [LANES*FP_W-1:0] result,
    output logic [LANES-1:0]      ovf_mask,
    output logic                  ovf_any
);

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [FP_W-1:0]  op_a [LANES];
    logic [FP_W-1:0]  op_b [LANES];
    logic [FP_W-1:0]  res  [LANES];
    logic [FP_W-1:0]  lane_val;
    logic             last;

    assign last = (idx == IDX_LAST);

`ifdef VMULT_SAT_EN
    assign lane_val = mul_ovf ? FP_W'({mul_a[FP_W-1] ^ mul_b[FP_W-1], FP16_MAX_FINITE})
                              : mul_prod;
`else
    assign lane_val = mul_prod;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            ovf_mask <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                op_a[i] <= '0;
                op_b[i] <= '0;
                res[i]  <= '0;
            end
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            op_a[i] <= vec_a[i*FP_W +: FP_W];
                            op_b[i] <= vec_b[i*FP_W +: FP_W];
                        end
                        idx      <= '0;
                        ovf_mask <= '0;
                    end
                end
                RUN: begin
                    res[idx]      <= lane_val;
                    ovf_mask[idx] <= mul_ovf;
                    // idx parks on the last lane rather than wrapping; the next start clears it.
                    if (!last) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        mul_a    = '0;
        mul_b    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                mul_a = op_a[idx];
                mul_b = op_b[idx];
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign ovf_any = |ovf_mask;

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign result[g*FP_W +: FP_W] = res[g];
    end

endmodule

// File: tb/tb_vmult_seq.sv
// Self-checking bench for vmult_seq: bench-side stand-in multiplier, job-level model, directed jobs.
module tb_vmult_seq;

    localparam int unsigned LANES = 8;
    localparam int unsigned FP_W  = 16;
    localparam int unsigned VW    = LANES * FP_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [VW-1:0]     vec_a;
    logic [VW-1:0]     vec_b;
    logic [FP_W-1:0]   mul_a;
    logic [FP_W-1:0]   mul_b;
    logic [FP_W-1:0]   mul_prod;
    logic              mul_ovf;
    logic              busy;
    logic              done;
    logic [VW-1:0]     result;
    logic [LANES-1:0]  ovf_mask;
    logic              ovf_any;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        chk_en = 1'b0;

    vmult_seq #(.LANES(LANES), .FP_W(FP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .vec_a    (vec_a),
        .vec_b    (vec_b),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_prod (mul_prod),
        .mul_ovf  (mul_ovf),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf_mask (ovf_mask),
        .ovf_any  (ovf_any)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: exact for powers of two, overflow when the biased exponent exceeds 30.
    function automatic logic [16:0] fake_mul(input logic [15:0] a, input logic [15:0] b);
        logic [5:0] es;
        logic       s;
        es = {1'b0, a[14:10]} + {1'b0, b[14:10]};
        s  = a[15] ^ b[15];
        if (es > 6'd45) return {1'b1, s, 15'h7C00};
        return {1'b0, s, 15'(a[14:0] + b[14:0] - 15'h3C00)};
    endfunction

    function automatic logic [15:0] lane_model(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        r = fake_mul(a, b);
`ifdef VMULT_SAT_EN
        if (r[16]) return {a[15] ^ b[15], 15'h7BFF};
`endif
        return r[15:0];
    endfunction

    function automatic logic lane_ovf(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        r = fake_mul(a, b);
        return r[16];
    endfunction

    always_comb {mul_ovf, mul_prod} = fake_mul(mul_a, mul_b);

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Job model: ph=0 idle, 1..LANES processing lane ph-1, LANES+1 done cycle.
    int unsigned      ph;
    logic [15:0]      cap_a   [LANES];
    logic [15:0]      cap_b   [LANES];
    logic [15:0]      exp_res [LANES];
    logic [LANES-1:0] exp_mask;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= 0;
            exp_mask <= '0;
            for (int i = 0; i < LANES; i++) exp_res[i] <= '0;
        end else if (ph == 0) begin
            if (start) begin
                ph       <= 1;
                exp_mask <= '0;
                for (int i = 0; i < LANES; i++) begin
                    cap_a[i] <= vec_a[i*FP_W +: FP_W];
                    cap_b[i] <= vec_b[i*FP_W +: FP_W];
                end
            end
        end else if (ph <= LANES) begin
            exp_res[ph-1]  <= lane_model(cap_a[ph-1], cap_b[ph-1]);
            exp_mask[ph-1] <= lane_ovf(cap_a[ph-1], cap_b[ph-1]);
            ph             <= ph + 1;
        end else begin
            ph <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin : cmp
            logic [VW-1:0] ev;
            logic          run;
            for (int i = 0; i < LANES; i++) ev[i*FP_W +: FP_W] = exp_res[i];
            run = (ph >= 1) && (ph <= LANES);
            check("busy",     VW'(busy),     VW'(ph != 0));
            check("done",     VW'(done),     VW'(ph == LANES + 1));
            check("mul_a",    VW'(mul_a),    run ? VW'(cap_a[ph-1]) : '0);
            check("mul_b",    VW'(mul_b),    run ? VW'(cap_b[ph-1]) : '0);
            check("result",   result,        ev);
            check("ovf_mask", VW'(ovf_mask), VW'(exp_mask));
            check("ovf_any",  VW'(ovf_any),  VW'(|exp_mask));
        end
    end

    function automatic logic [VW-1:0] fill(input logic [15:0] dflt, input int lane, input logic [15:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*FP_W +: FP_W] = (i == lane) ? v : dflt;
        return r;
    endfunction

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", VW'(busy), '0);
    endtask

    // Returns the negedge count (after the accepting edge) at which done was seen, 0 if never.
    task automatic run_job(input logic [VW-1:0] a, input logic [VW-1:0] b,
                           input int chg_k, input logic [VW-1:0] alt_a,
                           output int dk);
        dk = 0;
        wait_idle();
        @(negedge clk); #1;
        vec_a = a; vec_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                dk = k;
                break;
            end
            if (k == chg_k) begin
                #1 vec_a = alt_a;
            end
        end
    endtask

    logic [VW-1:0] one_v, two_v, a2, b2, a3, b3, sat3, sat0;
    int            dk;
    int            d1, d2, nd;

    initial begin
        rst_n = 1'b1; start = 1'b0; vec_a = '0; vec_b = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy",   VW'(busy),     '0);
        check("rst_done",   VW'(done),     '0);
        check("rst_result", result,        '0);
        check("rst_mask",   VW'(ovf_mask), '0);
        chk_en = 1'b1;
        #10 rst_n = 1'b1;

        one_v = {LANES{16'h3C00}};
        two_v = {LANES{16'h4000}};

        run_job(one_v, two_v, 0, '0, dk);
        check("j1_latency", VW'(dk), VW'(LANES + 1));
        check("j1_result",  result, {LANES{16'h4000}});
        check("j1_mask",    VW'(ovf_mask), '0);

        a2 = fill(16'h3C00, 3, 16'h7BFF);
        b2 = fill(16'h4000, 3, 16'h7BFF);
`ifdef VMULT_SAT_EN
        sat3 = fill(16'h4000, 3, 16'h7BFF);
`else
        sat3 = fill(16'h4000, 3, 16'h7C00);
`endif
        run_job(a2, b2, 0, '0, dk);
        check("j2_latency", VW'(dk), VW'(LANES + 1));
        check("j2_mask",    VW'(ovf_mask), VW'(8'h08));
        check("j2_any",     VW'(ovf_any),  VW'(1'b1));
        check("j2_result",  result, sat3);

        a3 = fill(16'h3C00, 0, 16'hFBFF);
        b3 = fill(16'h4000, 0, 16'h7BFF);
`ifdef VMULT_SAT_EN
        sat0 = fill(16'h4000, 0, 16'hFBFF);
`else
        sat0 = fill(16'h4000, 0, 16'hFC00);
`endif
        run_job(a3, b3, 0, '0, dk);
        check("j3_mask",   VW'(ovf_mask), VW'(8'h01));
        check("j3_result", result, sat0);

        // Idle hold: values persist after done.
        repeat (3) @(negedge clk);
        check("hold_result", result, sat0);

        // start held for 20 edges: two jobs, the third request lands in DONE and is dropped.
        wait_idle();
        @(negedge clk); #1;
        vec_a = two_v; vec_b = two_v; start = 1'b1;
        @(posedge clk);
        d1 = 0; d2 = 0; nd = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) d1 = k;
                if (nd == 2) d2 = k;
            end
            if (k == 20) begin
                #1 start = 1'b0;
            end
        end
        check("stream_count", VW'(nd), VW'(2));
        check("stream_d1",    VW'(d1), VW'(9));
        check("stream_d2",    VW'(d2), VW'(19));
        check("stream_res",   result, {LANES{16'h4400}});

        // Operand change after acceptance has no effect.
        run_job(two_v, two_v, 2, one_v, dk);
        check("capt_latency", VW'(dk), VW'(LANES + 1));
        check("capt_result",  result, {LANES{16'h4400}});

        // Asynchronous reset mid-job.
        wait_idle();
        @(negedge clk); #1;
        vec_a = one_v; vec_b = two_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy",   VW'(busy),     '0);
        check("arst_done",   VW'(done),     '0);
        check("arst_result", result,        '0);
        check("arst_mask",   VW'(ovf_mask), '0);
        @(negedge clk); #1 rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("arst_nodone", VW'(nd), '0);

        run_job(one_v, two_v, 0, '0, dk);
        check("post_latency", VW'(dk), VW'(LANES + 1));
        check("post_result",  result, {LANES{16'h4000}});

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
